truth_table_sweeper: RTL and testbench

- Sequencer/collector that drives a 4-input logic stage (simplification function followed by T flip-flop) through all minterms.
- Captures the stage's registered response per minterm and presents the completed truth table over a valid/ready handshake.
- Sits directly upstream (drives a,b,c,d) and downstream (consumes Q) of the simplification + tff stage.
- Replaces hand-written #20 stimulus lists with a synthesizable sweep.

---
 rtl/truth_table_sweeper_pkg.sv | 25 ++
 rtl/truth_table_sweeper_hold_timer.sv | 32 +++
 rtl/truth_table_sweeper.sv | 105 ++++++++++
 tb/tb_truth_table_sweeper.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM encoding,
// default sizing and width helpers used by the top and its hold timer.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } sweep_state_e;

  localparam int N_VARS_DEFAULT      = 4;
  localparam int HOLD_CYCLES_DEFAULT = 4;

  // Number of minterms (table width) for a given input count.
  function automatic int table_width(input int n_vars);
    return 1 << n_vars;
  endfunction

  // Hold counter width; never narrower than one bit.
  function automatic int hold_cnt_width(input int hold_cycles);
    return (hold_cycles > 2) ? $clog2(hold_cycles) : 1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// Loadable down-counter timing one minterm hold window; flags the first
// cycle after a load and the terminal count.
module hold_timer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CW          = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic load,
  input  logic en,
  output logic first,
  output logic tc
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && !tc) begin
      count <= count - CW'(1);
    end
  end

  assign tc    = (count == '0);
  assign first = (count == LOAD_VAL);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 4-input stage through every minterm, holds each for HOLD_CYCLES
// clocks, records the stage's settled output and any in-window toggling.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_VARS      = N_VARS_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                              clk,
  input  logic                              clr_n,
  input  logic                              start,
  output logic [N_VARS-1:0]                 vars,
  input  logic                              q_in,
  output logic                              busy,
  output logic [table_width(N_VARS)-1:0]    table_q,
  output logic [table_width(N_VARS)-1:0]    toggled,
  output logic                              out_valid,
  input  logic                              out_ready,
  output sweep_state_e                      dbg_state
);

  localparam int                CW   = hold_cnt_width(HOLD_CYCLES);
  localparam logic [N_VARS-1:0] LAST = '1;

  // Result handshake: out_valid stays high with table_q/toggled frozen until
  // a cycle where out_ready is also high; that cycle transfers the result and
  // the FSM returns to IDLE. Valid never drops without ready.

  sweep_state_e state_q, state_d;
  logic         timer_load, timer_en, timer_first, timer_tc;
  logic         q_prev;
  logic         last_minterm;

  assign last_minterm = (vars == LAST);
  assign dbg_state    = state_q;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CW          (CW)
  ) u_hold_timer (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (timer_load),
    .en    (timer_en),
    .first (timer_first),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = HOLD;
      HOLD:    if (timer_tc) state_d = CAPTURE;
      CAPTURE: state_d = last_minterm ? DONE : HOLD;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == HOLD) || (state_q == CAPTURE);
    out_valid  = (state_q == DONE);
    timer_load = ((state_q == IDLE) && start) || (state_q == CAPTURE);
    timer_en   = (state_q == HOLD);
  end

  // The first hold cycle still sees the previous minterm's transition, so
  // toggles are only counted from the second cycle onward.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vars    <= '0;
      table_q <= '0;
      toggled <= '0;
      q_prev  <= 1'b0;
    end else begin
      q_prev <= q_in;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            vars    <= '0;
            table_q <= '0;
            toggled <= '0;
          end
        end
        HOLD: begin
          if (!timer_first && (q_in != q_prev)) toggled[vars] <= 1'b1;
        end
        CAPTURE: begin
          table_q[vars] <= q_in;
          if (!last_minterm) vars <= vars + N_VARS'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: constant, real T-flop stage and random
// response sweeps, backpressure, mid-sweep reset and a small parameter corner.
module tb_truth_table_sweeper;
  import sweep_pkg::*;

  localparam int NV    = 4;
  localparam int HC    = 4;
  localparam int TW    = 1 << NV;
  localparam int SWEEP = TW * (HC + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n, start, out_ready, q_in, busy, out_valid;
  logic [NV-1:0] vars;
  logic [TW-1:0] table_q, toggled;
  sweep_state_e  dbg_state;

  logic       start2, out_ready2, q_in2, busy2, out_valid2;
  logic [1:0] vars2;
  logic [3:0] table2, toggled2;
  sweep_state_e dbg_state2;

  int checks   = 0;
  int failures = 0;

  int            mode;
  logic          q_drv;
  logic          tff_q;
  logic          stage_t;
  logic          q_rec [0:SWEEP];
  logic [TW-1:0] exp_q [$];
  logic [TW-1:0] last_tab, last_tog;

  truth_table_sweeper #(.N_VARS(NV), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .vars(vars), .q_in(q_in),
    .busy(busy), .table_q(table_q), .toggled(toggled), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  truth_table_sweeper #(.N_VARS(2), .HOLD_CYCLES(2)) dut2 (
    .clk(clk), .clr_n(clr_n), .start(start2), .vars(vars2), .q_in(q_in2),
    .busy(busy2), .table_q(table2), .toggled(toggled2), .out_valid(out_valid2),
    .out_ready(out_ready2), .dbg_state(dbg_state2)
  );

  // Stage under sweep: simplified function feeding a T flip-flop.
  assign stage_t = (vars[1] | vars[0]) & (vars[2] | vars[1]) & (vars[2] | vars[0]) &
                   (~vars[2] | ~vars[1] | ~vars[0]);
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) tff_q <= 1'b0;
    else if (stage_t) tff_q <= ~tff_q;
  end

  assign q_in  = (mode == 1) ? tff_q : q_drv;
  assign q_in2 = vars2[0];

  function automatic int t_of(input int m);
    bit b, c, d;
    b = m[2]; c = m[1]; d = m[0];
    return int'((c | d) & (b | c) & (b | d) & (~b | ~c | ~d));
  endfunction

  // Each minterm spends HC+1 flop edges with T applied, but only HC of them
  // land before its own capture.
  function automatic logic [TW-1:0] tff_model();
    logic [TW-1:0] r;
    int n;
    n = 0;
    for (int m = 0; m < TW; m++) begin
      r[m] = 1'((n + HC * t_of(m)) % 2);
      n += (HC + 1) * t_of(m);
    end
    return r;
  endfunction

  // md: 0 = q_in constant 1, 1 = T-flop stage, 2 = random per cycle.
  task automatic do_sweep(input int md, input bit noisy_start, input string name);
    int lat, vars_err, busy_err, base;
    logic [TW-1:0] e_tab, e_tog, exp_v;
    mode = md; lat = -1; vars_err = 0; busy_err = 0;
    @(negedge clk);
    if (md == 0) q_drv = 1'b1;
    else if (md == 2) q_drv = 1'($urandom_range(0, 1));
    q_rec[0] = (md == 1) ? tff_q : q_drv;
    start = 1'b1;
    for (int e = 1; e <= SWEEP + 20; e++) begin
      @(negedge clk);
      start = noisy_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (md == 2) q_drv = 1'($urandom_range(0, 1));
      if (e <= SWEEP) begin
        q_rec[e] = (md == 1) ? tff_q : q_drv;
        if (vars !== NV'((e - 1) / (HC + 1))) vars_err++;
        if (busy !== 1'b1 || out_valid !== 1'b0) busy_err++;
      end
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = e;
        break;
      end
    end
    for (int m = 0; m < TW; m++) begin
      base = m * (HC + 1);
      e_tab[m] = q_rec[base + HC + 1];
      e_tog[m] = 1'b0;
      for (int e = base + 2; e <= base + HC; e++)
        if (q_rec[e] != q_rec[e - 1]) e_tog[m] = 1'b1;
    end
    exp_q.push_back(e_tab);
    exp_q.push_back(e_tog);
    last_tab = e_tab; last_tog = e_tog;
    checks++;
    if (lat != SWEEP) begin
      failures++; $display("FAIL %s latency: got %0d expected %0d", name, lat, SWEEP);
    end
    checks++;
    if (vars_err != 0 || busy_err != 0) begin
      failures++;
      $display("FAIL %s sequencing: vars errors %0d busy errors %0d expected 0", name, vars_err, busy_err);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (table_q !== exp_v) begin
      failures++; $display("FAIL %s table_q: got %h expected %h", name, table_q, exp_v);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (toggled !== exp_v) begin
      failures++; $display("FAIL %s toggled: got %h expected %h", name, toggled, exp_v);
    end
    @(negedge clk);
    start = 1'b0;
    if (out_ready) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || dbg_state !== IDLE || table_q !== e_tab) begin
        failures++;
        $display("FAIL %s handshake: valid %b state %0d table %h expected 0 0 %h",
                 name, out_valid, dbg_state, table_q, e_tab);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; out_ready = 1'b0; start2 = 1'b0; out_ready2 = 1'b0;
    mode = 0; q_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vars !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || table_q !== '0 ||
        toggled !== '0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state: vars %h busy %b valid %b table %h tog %h expected all 0",
               vars, busy, out_valid, table_q, toggled);
    end
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (vars !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || table_q !== '0) begin
        failures++;
        $display("FAIL idle cycle %0d: vars %h busy %b valid %b table %h expected all 0",
                 i, vars, busy, out_valid, table_q);
      end
    end
  endtask

  task automatic test_constant();
    out_ready = 1'b1;
    do_sweep(0, 1'b0, "constant");
    checks++;
    if (table_q !== 16'hFFFF || toggled !== 16'h0000) begin
      failures++;
      $display("FAIL constant_result: table %h toggled %h expected ffff 0000", table_q, toggled);
    end
  endtask

  task automatic test_stage();
    logic [TW-1:0] exp_tab;
    out_ready = 1'b1;
    do_sweep(1, 1'b0, "stage");
    exp_tab = tff_model();
    checks++;
    if (toggled !== 16'h6868) begin
      failures++; $display("FAIL stage_toggled: got %h expected 6868", toggled);
    end
    checks++;
    if (table_q !== exp_tab) begin
      failures++; $display("FAIL stage_flop_model: got %h expected %h", table_q, exp_tab);
    end
  endtask

  task automatic test_random();
    out_ready = 1'b1;
    repeat (3) do_sweep(2, 1'b1, "random");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    do_sweep(2, 1'b0, "backpressure");
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || table_q !== last_tab || toggled !== last_tog || dbg_state !== DONE) begin
        failures++;
        $display("FAIL bp_hold %0d: valid %b table %h tog %h expected 1 %h %h",
                 i, out_valid, table_q, toggled, last_tab, last_tog);
      end
      @(negedge clk);
    end
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL bp_release: valid %b busy %b state %0d expected 0 0 0", out_valid, busy, dbg_state);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== IDLE || busy !== 1'b0 || table_q !== last_tab || toggled !== last_tog) begin
      failures++;
      $display("FAIL bp_start_ignored: state %0d busy %b table %h expected 0 0 %h",
               dbg_state, busy, table_q, last_tab);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit found;
    out_ready = 1'b1; mode = 2; found = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (vars == NV'(7)) begin
        found = 1'b1;
        break;
      end
      q_drv = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL reset_mid_reach: vars %h expected 7", vars);
    end
    clr_n = 1'b0;
    #1;
    checks++;
    if (vars !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || table_q !== '0 ||
        toggled !== '0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_mid_clear: vars %h busy %b valid %b table %h tog %h expected all 0",
               vars, busy, out_valid, table_q, toggled);
    end
    @(negedge clk);
    clr_n = 1'b1;
    do_sweep(1, 1'b0, "after_reset");
    checks++;
    if (toggled !== 16'h6868 || table_q !== tff_model()) begin
      failures++;
      $display("FAIL after_reset_result: table %h tog %h expected %h 6868", table_q, toggled, tff_model());
    end
  endtask

  task automatic test_param_corner();
    int lat;
    lat = -1; out_ready2 = 1'b1;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (out_valid2 === 1'b1) begin
        lat = e;
        break;
      end
    end
    checks++;
    if (lat != 12) begin
      failures++; $display("FAIL corner_latency: got %0d expected 12", lat);
    end
    checks++;
    if (table2 !== 4'b1010 || toggled2 !== 4'b0000) begin
      failures++; $display("FAIL corner_table: table %b tog %b expected 1010 0000", table2, toggled2);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid2 !== 1'b0 || dbg_state2 !== IDLE) begin
      failures++; $display("FAIL corner_handshake: valid %b state %0d expected 0 0", out_valid2, dbg_state2);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_constant();
    test_stage();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_param_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
